pio_loader: RTL
===============

PIO_LOADER -- requirements
Module: pio_loader

Interface
REQ-001 SHALL have parameter IMG_DEPTH, default 64, meaning image memory entries (program plus config).
REQ-002 SHALL have parameter MAX_PROG, default 32, meaning PIO instruction memory size.
REQ-003 SHALL have port clk_25mhz  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle load request; sampled only in IDLE.
REQ-006 SHALL have port sm_sel  input  2  target state machine; latched on accepted start.
REQ-007 SHALL have port prog_len  input  6  instruction count; latched on accepted start.
REQ-008 SHALL have port cfg_len  input  6  config entry count; latched on accepted start.
REQ-009 SHALL have port img_addr  output  6  image read address.
REQ-010 SHALL have port img_data  input  36  image read data, valid one cycle after img_addr; format {action[3:0], din[31:0]}.
REQ-011 SHALL have port action  output  4  PIO command code, 0 = no-op.
REQ-012 SHALL have port index  output  5  PIO instruction slot.
REQ-013 SHALL have port din  output  32  PIO command data.
REQ-014 SHALL have port mindex  output  2  PIO state machine select.
REQ-015 SHALL have ports busy, done, err  output  1 each  sequence active; one-cycle completion pulse; sticky error flag, cleared on accepted start.

Function
REQ-016 SHALL implement states IDLE, DISABLE, PROG, CFG, FIN.
REQ-017 SHALL, in IDLE with start=1 at cycle T, latch sm_sel, prog_len, cfg_len; clear err; enter DISABLE at T+1.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL, at T+1 (DISABLE), drive action=6, din=0, mindex=sm_sel, img_addr=0; go to PROG.
REQ-020 SHALL, for program word k (0..prog_len-1), drive at T+2+k: action=1, index=k, din={16'b0, img_data[15:0]}.
REQ-021 SHALL, for config entry j (0..cfg_len-1), drive at T+2+prog_len+j: action=img_data[35:32], din=img_data[31:0], image address prog_len+j.
REQ-022 SHALL advance img_addr by one each cycle so one command issues per cycle with no bubbles.
REQ-023 SHALL hold mindex=latched sm_sel for every command in the sequence.
REQ-024 SHALL, when a config entry's action field is 1 or 0, issue action=0 for that cycle and set err.
REQ-025 SHALL abort at T+1 with err=1, done=1, no commands issued, when prog_len=0 or prog_len>MAX_PROG or prog_len+cfg_len>IMG_DEPTH.
REQ-026 SHALL allow cfg_len=0: FIN follows the last program word directly.
REQ-027 SHALL, in FIN, drive action=0, pulse done for one cycle, return to IDLE next cycle.
REQ-028 SHALL assert busy from T+1 through the FIN cycle inclusive.
REQ-029 SHALL drive action=0 in every cycle not listed above.

Reset
REQ-030 SHALL, on reset, force state IDLE; action, index, din, mindex, img_addr = 0; busy, done, err = 0.
REQ-031 SHALL, on reset mid-sequence, drop action to 0 the next cycle and never emit done for the aborted sequence.
REQ-032 SHALL accept start on the first cycle after reset deasserts.

Structure
REQ-033 SHALL take action codes (NOP=0, LOAD=1, WRAP=2, PINS=5, ENABLE=6, DIV=7, SIDESET=8), field widths, and image entry format from shared package pio_pkg.
REQ-034 SHALL be a single module with no sub-module; the image memory is external.

Verification
REQ-035 SHALL verify: prog_len=12, cfg_len=5, sm_sel=0, start at T -> action 6 at T+1; action 1 index 0..11 at T+2..T+13; config actions 2,7,5,8,6 at T+14..T+18; done at T+19.
REQ-036 SHALL verify: prog_len=4, cfg_len=0, sm_sel=2 -> 4 loads with mindex=2, done at T+6, err=0.
REQ-037 SHALL verify: prog_len=0 or prog_len=33 -> done and err at T+1, action 0 throughout.
REQ-038 SHALL verify: config entry 36'h1_0000_0005 at position j=1 -> action 0 in its cycle, err=1, sequence still completes.
REQ-039 SHALL verify: reset asserted at T+5 of a 12-word load -> action 0 and busy 0 the next cycle, no done; a new start then completes normally.
REQ-040 SHALL verify: start pulsed while busy -> ignored, sequence timing unchanged.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared PIO definitions: command codes, field widths and the image entry layout.
package pio_pkg;

  localparam int unsigned ACTION_W = 4;
  localparam int unsigned DIN_W    = 32;
  localparam int unsigned INDEX_W  = 5;
  localparam int unsigned MINDEX_W = 2;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned LEN_W    = 6;
  localparam int unsigned PROG_W   = 16;
  localparam int unsigned IMG_W    = ACTION_W + DIN_W;

  localparam logic [ACTION_W-1:0] ACT_NOP     = 4'd0;
  localparam logic [ACTION_W-1:0] ACT_LOAD    = 4'd1;
  localparam logic [ACTION_W-1:0] ACT_WRAP    = 4'd2;
  localparam logic [ACTION_W-1:0] ACT_PINS    = 4'd5;
  localparam logic [ACTION_W-1:0] ACT_ENABLE  = 4'd6;
  localparam logic [ACTION_W-1:0] ACT_DIV     = 4'd7;
  localparam logic [ACTION_W-1:0] ACT_SIDESET = 4'd8;

  typedef struct packed {
    logic [ACTION_W-1:0] action;
    logic [DIN_W-1:0]    din;
  } img_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DISABLE = 3'd1,
    ST_PROG    = 3'd2,
    ST_CFG     = 3'd3,
    ST_FIN     = 3'd4
  } state_t;

  // Config entries may not carry NOP or LOAD; those are reserved for the loader itself.
  function automatic logic cfg_action_ok(input logic [ACTION_W-1:0] a);
    return (a != ACT_NOP) && (a != ACT_LOAD);
  endfunction

endpackage

// File: rtl/pio_loader.sv
// Streams a PIO program plus config entries from an external image memory into
// one PIO state machine: disable, load instructions, apply config, report done.
module pio_loader
  import pio_pkg::*;
#(
  parameter int unsigned IMG_DEPTH = 64,
  parameter int unsigned MAX_PROG  = 32
) (
  input  logic                clk_25mhz,
  input  logic                reset,
  input  logic                start,
  input  logic [MINDEX_W-1:0] sm_sel,
  input  logic [LEN_W-1:0]    prog_len,
  input  logic [LEN_W-1:0]    cfg_len,
  output logic [ADDR_W-1:0]   img_addr,
  input  logic [IMG_W-1:0]    img_data,
  output logic [ACTION_W-1:0] action,
  output logic [INDEX_W-1:0]  index,
  output logic [DIN_W-1:0]    din,
  output logic [MINDEX_W-1:0] mindex,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    prog_q, cfg_q, cnt, cnt_nxt;
  logic [MINDEX_W-1:0] sm_q;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [LEN_W:0]      req_total, cur_total, addr_inc;
  logic                params_bad, prog_last, cfg_last, cfg_reject;
  img_entry_t          entry;

  assign entry     = img_entry_t'(img_data);
  assign req_total = (LEN_W+1)'(prog_len) + (LEN_W+1)'(cfg_len);
  assign cur_total = (LEN_W+1)'(prog_q) + (LEN_W+1)'(cfg_q);
  assign addr_inc  = (LEN_W+1)'(img_addr) + (LEN_W+1)'(1);
  assign prog_last = (cnt == prog_q - LEN_W'(1));
  assign cfg_last  = (cnt == cfg_q - LEN_W'(1));

  assign params_bad = (prog_len == '0) || (32'(prog_len) > MAX_PROG) ||
                      (32'(req_total) > IMG_DEPTH);

  // State register.
  always_ff @(posedge clk_25mhz) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, phase counter and image fetch address.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    addr_nxt  = '0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = params_bad ? ST_FIN : ST_DISABLE;
      end
      ST_DISABLE: begin
        state_nxt = ST_PROG;
      end
      ST_PROG: begin
        if (prog_last) state_nxt = (cfg_q == '0) ? ST_FIN : ST_CFG;
        else           cnt_nxt   = cnt + LEN_W'(1);
      end
      ST_CFG: begin
        if (cfg_last) state_nxt = ST_FIN;
        else          cnt_nxt   = cnt + LEN_W'(1);
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Fetch runs one cycle ahead of issue and parks on the last image entry.
    if (state == ST_DISABLE || state == ST_PROG || state == ST_CFG) begin
      addr_nxt = (addr_inc < cur_total) ? img_addr + ADDR_W'(1) : img_addr;
    end
  end

  // Command outputs follow the image data the same cycle it arrives.
  always_comb begin
    action     = ACT_NOP;
    index      = '0;
    din        = '0;
    cfg_reject = 1'b0;
    case (state)
      ST_DISABLE: begin
        action = ACT_ENABLE;
      end
      ST_PROG: begin
        action = ACT_LOAD;
        index  = cnt[INDEX_W-1:0];
        din    = DIN_W'(entry.din[PROG_W-1:0]);
      end
      ST_CFG: begin
        if (cfg_action_ok(entry.action)) begin
          action = entry.action;
          din    = entry.din;
        end else begin
          cfg_reject = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Latched request, counters and status flags.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      prog_q   <= '0;
      cfg_q    <= '0;
      sm_q     <= '0;
      cnt      <= '0;
      img_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      img_addr <= addr_nxt;
      busy     <= (state_nxt != ST_IDLE);
      done     <= (state_nxt == ST_FIN);
      if (state == ST_IDLE && start) begin
        prog_q <= prog_len;
        cfg_q  <= cfg_len;
        sm_q   <= sm_sel;
        err    <= params_bad;
      end else if (cfg_reject) begin
        err <= 1'b1;
      end
    end
  end

  assign mindex = sm_q;

endmodule
